// File: rtl/rollback_walk_ctrl.sv
// Branch-recovery walker: on a mispredict, walks the ROB from youngest entry back to the branch,
// restoring Map Table entries and returning squashed physical registers, then reloads the ROB tail.
module rollback_walk_ctrl #(
  parameter int NUM_ROB   = 32,
  parameter int NUM_SUPER = 2,
  parameter int NUM_PR    = 64,
  parameter int ZERO_REG  = 31
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  rollback_en,
  input  logic [$clog2(NUM_ROB)-1:0]            ROB_rollback_idx,
  input  logic [$clog2(NUM_ROB)-1:0]            ROB_tail_idx,
  output logic [NUM_SUPER*$clog2(NUM_ROB)-1:0]  rd_idx,
  output logic [NUM_SUPER-1:0]                  rd_valid,
  input  logic [NUM_SUPER*5-1:0]                rd_dest_idx,
  input  logic [NUM_SUPER*$clog2(NUM_PR)-1:0]   rd_T_idx,
  input  logic [NUM_SUPER*$clog2(NUM_PR)-1:0]   rd_Told_idx,
  output logic [NUM_SUPER-1:0]                  mt_restore_en,
  output logic [NUM_SUPER*5-1:0]                mt_restore_dest_idx,
  output logic [NUM_SUPER*$clog2(NUM_PR)-1:0]   mt_restore_Told_idx,
  output logic [NUM_SUPER-1:0]                  fl_return_en,
  output logic [NUM_SUPER*$clog2(NUM_PR)-1:0]   fl_return_T_idx,
  output logic                                  stall_dispatch,
  output logic                                  busy,
  output logic                                  rob_tail_load,
  output logic [$clog2(NUM_ROB)-1:0]            rob_tail_new,
  output logic                                  done
);

  localparam int IW = $clog2(NUM_ROB);
  localparam int PW = $clog2(NUM_PR);
  localparam int RW = IW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] cur;
  logic [RW-1:0] remain;
  logic [IW-1:0] saved_rb_idx;
  logic [IW-1:0] init_remain;
  logic [RW-1:0] step;
  logic          walking;
  logic [NUM_SUPER-1:0] lane_live;

  function automatic logic [RW-1:0] min_step(input logic [RW-1:0] r);
    return (r > RW'(NUM_SUPER)) ? RW'(NUM_SUPER) : r;
  endfunction

  // Entries strictly between the branch and the tail, modulo ROB size.
  assign init_remain = ROB_tail_idx - ROB_rollback_idx - IW'(1);
  assign step        = min_step(remain);
  assign walking     = (state == ST_WALK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cur          <= '0;
      remain       <= '0;
      saved_rb_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rollback_en) begin
            cur          <= ROB_tail_idx - IW'(1);
            remain       <= {1'b0, init_remain};
            saved_rb_idx <= ROB_rollback_idx;
            state        <= (init_remain != '0) ? ST_WALK : ST_DONE;
          end
        end
        ST_WALK: begin
          cur    <= cur - step[IW-1:0];
          remain <= remain - step;
          if (remain == step) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane k reads cur-k; strobes follow the same-cycle ROB read and skip the zero register.
  always_comb begin
    rd_idx              = '0;
    rd_valid            = '0;
    lane_live           = '0;
    mt_restore_en       = '0;
    mt_restore_dest_idx = '0;
    mt_restore_Told_idx = '0;
    fl_return_en        = '0;
    fl_return_T_idx     = '0;
    for (int k = 0; k < NUM_SUPER; k++) begin
      lane_live[k] = walking && (RW'(k) < remain);
      if (walking) rd_idx[k*IW +: IW] = cur - IW'(k);
      rd_valid[k] = lane_live[k];
      if (lane_live[k] && (rd_dest_idx[k*5 +: 5] != 5'(ZERO_REG))) begin
        mt_restore_en[k]              = 1'b1;
        mt_restore_dest_idx[k*5 +: 5] = rd_dest_idx[k*5 +: 5];
        mt_restore_Told_idx[k*PW +: PW] = rd_Told_idx[k*PW +: PW];
        fl_return_en[k]               = 1'b1;
        fl_return_T_idx[k*PW +: PW]   = rd_T_idx[k*PW +: PW];
      end
    end
  end

  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);
  assign rob_tail_load  = done;
  assign rob_tail_new   = done ? (saved_rb_idx + IW'(1)) : '0;
  // Gated by reset so a request held during reset does not leak onto the stall line.
  assign stall_dispatch = busy | (rollback_en & reset);

endmodule

// File: tb/tb_rollback_walk_ctrl.sv
// Randomized and directed bench for rollback_walk_ctrl against a queue-based walk model.
module tb_rollback_walk_ctrl;
  localparam int NR = 32;
  localparam int NS = 2;
  localparam int IW = 5;
  localparam int PW = 6;

  logic clock = 1'b0;
  logic reset;
  logic rollback_en;
  logic [IW-1:0] ROB_rollback_idx, ROB_tail_idx;
  logic [NS*IW-1:0] rd_idx;
  logic [NS-1:0] rd_valid;
  logic [NS*5-1:0] rd_dest_idx;
  logic [NS*PW-1:0] rd_T_idx, rd_Told_idx;
  logic [NS-1:0] mt_restore_en, fl_return_en;
  logic [NS*5-1:0] mt_restore_dest_idx;
  logic [NS*PW-1:0] mt_restore_Told_idx, fl_return_T_idx;
  logic stall_dispatch, busy, rob_tail_load, done;
  logic [IW-1:0] rob_tail_new;

  int checks = 0;
  int errors = 0;
  int rob_dest [NR];
  int rob_T    [NR];
  int rob_Told [NR];
  int mt_obs [32];
  int mt_exp [32];

  rollback_walk_ctrl #(.NUM_ROB(NR), .NUM_SUPER(NS), .NUM_PR(64), .ZERO_REG(31)) dut (
    .clock(clock), .reset(reset), .rollback_en(rollback_en),
    .ROB_rollback_idx(ROB_rollback_idx), .ROB_tail_idx(ROB_tail_idx),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_dest_idx(rd_dest_idx),
    .rd_T_idx(rd_T_idx), .rd_Told_idx(rd_Told_idx),
    .mt_restore_en(mt_restore_en), .mt_restore_dest_idx(mt_restore_dest_idx),
    .mt_restore_Told_idx(mt_restore_Told_idx), .fl_return_en(fl_return_en),
    .fl_return_T_idx(fl_return_T_idx), .stall_dispatch(stall_dispatch), .busy(busy),
    .rob_tail_load(rob_tail_load), .rob_tail_new(rob_tail_new), .done(done)
  );

  always #5 clock = ~clock;

  // ROB storage answering the controller's combinational reads.
  always_comb begin
    rd_dest_idx = '0;
    rd_T_idx    = '0;
    rd_Told_idx = '0;
    for (int k = 0; k < NS; k++) begin
      rd_dest_idx[k*5 +: 5]  = 5'(rob_dest[rd_idx[k*IW +: IW]]);
      rd_T_idx[k*PW +: PW]   = 6'(rob_T[rd_idx[k*IW +: IW]]);
      rd_Told_idx[k*PW +: PW] = 6'(rob_Told[rd_idx[k*IW +: IW]]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rob();
    for (int i = 0; i < NR; i++) begin
      rob_dest[i] = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 30));
      rob_T[i]    = int'($urandom_range(0, 63));
      rob_Told[i] = int'($urandom_range(0, 63));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: squashed entries are tail-1 down to rb+1; each cycle consumes up to NS of them.
  task automatic run_rb(input int rb, input int tail, input bit poke);
    int q[$];
    int fl_exp[$];
    int fl_got[$];
    int n, cyc, lanes, idx, diffs;
    logic [NS-1:0] ev, een;
    n = (((tail - rb - 1) % NR) + NR) % NR;
    for (int i = 0; i < n; i++) q.push_back((tail - 1 - i) & (NR - 1));
    for (int r = 0; r < 32; r++) begin mt_obs[r] = -1; mt_exp[r] = -1; end
    foreach (q[i]) if (rob_dest[q[i]] != 31) begin
      mt_exp[rob_dest[q[i]]] = rob_Told[q[i]];
      fl_exp.push_back(rob_T[q[i]]);
    end
    rollback_en = 1'b1;
    ROB_rollback_idx = IW'(rb);
    ROB_tail_idx = IW'(tail);
    #1;
    chk("accept_stall", 32'(stall_dispatch), 32'd1);
    chk("accept_busy", 32'(busy), 32'd0);
    tick();
    rollback_en = 1'b0;
    cyc = 0;
    while (q.size() > 0) begin
      if (poke && cyc == 1) rollback_en = 1'b0;
      lanes = (q.size() < NS) ? q.size() : NS;
      ev = '0; een = '0;
      for (int k = 0; k < lanes; k++) begin
        idx = q[k];
        ev[k] = 1'b1;
        een[k] = (rob_dest[idx] != 31);
        chk($sformatf("rd_idx%0d", k), 32'(rd_idx[k*IW +: IW]), 32'(idx));
        if (een[k]) begin
          chk($sformatf("mt_dest%0d", k), 32'(mt_restore_dest_idx[k*5 +: 5]), 32'(rob_dest[idx]));
          chk($sformatf("mt_told%0d", k), 32'(mt_restore_Told_idx[k*PW +: PW]), 32'(rob_Told[idx]));
          chk($sformatf("fl_t%0d", k), 32'(fl_return_T_idx[k*PW +: PW]), 32'(rob_T[idx]));
        end
      end
      chk("rd_valid", 32'(rd_valid), 32'(ev));
      chk("mt_en", 32'(mt_restore_en), 32'(een));
      chk("fl_en", 32'(fl_return_en), 32'(een));
      chk("walk_done", 32'(done), 32'd0);
      chk("walk_stall", 32'(stall_dispatch), 32'd1);
      for (int k = 0; k < NS; k++) begin
        if (mt_restore_en[k]) mt_obs[mt_restore_dest_idx[k*5 +: 5]] = int'(mt_restore_Told_idx[k*PW +: PW]);
        if (fl_return_en[k]) fl_got.push_back(int'(fl_return_T_idx[k*PW +: PW]));
      end
      for (int k = 0; k < lanes; k++) void'(q.pop_front());
      if (poke && cyc == 0) begin
        rollback_en = 1'b1;
        ROB_rollback_idx = IW'($urandom_range(0, NR - 1));
        ROB_tail_idx = IW'($urandom_range(0, NR - 1));
      end
      tick();
      cyc++;
    end
    rollback_en = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("tail_load", 32'(rob_tail_load), 32'd1);
    chk("tail_new", 32'(rob_tail_new), 32'((rb + 1) % NR));
    chk("done_stall", 32'(stall_dispatch), 32'd1);
    chk("done_strobes", 32'({mt_restore_en, fl_return_en, rd_valid}), 32'd0);
    tick();
    chk("idle_busy", 32'({busy, done, stall_dispatch}), 32'd0);
    diffs = 0;
    for (int r = 0; r < 32; r++) if (mt_obs[r] != mt_exp[r]) diffs++;
    chk("map_diffs", 32'(diffs), 32'd0);
    chk("fl_count", 32'(fl_got.size()), 32'(fl_exp.size()));
    if (fl_got.size() == fl_exp.size())
      foreach (fl_exp[i]) if (fl_got[i] != fl_exp[i]) chk("fl_order", 32'(fl_got[i]), 32'(fl_exp[i]));
  endtask

  initial begin
    reset = 1'b0;
    rollback_en = 1'b1;
    ROB_rollback_idx = 5'd3;
    ROB_tail_idx = 5'd9;
    fill_rob();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", 32'({busy, done, rob_tail_load, stall_dispatch, rd_valid, mt_restore_en, fl_return_en}), 32'd0);
      chk("reset_tail_new", 32'(rob_tail_new), 32'd0);
    end
    rollback_en = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_reset_busy", 32'(busy), 32'd0);

    run_rb(5, 10, 1'b0);
    run_rb(30, 2, 1'b0);
    run_rb(7, 8, 1'b0);

    fill_rob();
    rob_dest[9] = 3; rob_T[9] = 40; rob_Told[9] = 12;
    rob_dest[8] = 3; rob_T[8] = 12; rob_Told[8] = 9;
    rob_dest[10] = 31;
    run_rb(7, 11, 1'b0);
    chk("r3_final", 32'(mt_obs[3]), 32'd9);

    fill_rob();
    rollback_en = 1'b1;
    ROB_rollback_idx = 5'd0;
    ROB_tail_idx = 5'd10;
    tick();
    rollback_en = 1'b0;
    chk("mid_valid1", 32'(rd_valid), 32'd3);
    tick();
    chk("mid_idx2", 32'(rd_idx[IW-1:0]), 32'd7);
    reset = 1'b0;
    #1;
    chk("mid_async", 32'({busy, done, stall_dispatch, rd_valid, mt_restore_en, fl_return_en}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_nodone", 32'({done, rob_tail_load}), 32'd0);
    end
    reset = 1'b1;
    tick();
    run_rb(0, 10, 1'b1);

    fill_rob();
    run_rb(12, 12, 1'b0);
    for (int t = 0; t < 20; t++) begin
      fill_rob();
      run_rb(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
